// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I pipeline: widths, result-source encodings
// and the ID/EX stage register layout.
package riscv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned ALUCTRL_W = 3;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  typedef struct packed {
    logic                 reg_write;
    logic                 mem_write;
    logic                 jump;
    logic                 branch;
    logic                 alu_src;
    logic [1:0]           result_src;
    logic [ALUCTRL_W-1:0] alu_control;
    logic [XLEN-1:0]      rd1;
    logic [XLEN-1:0]      rd2;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      pc_plus4;
    logic [XLEN-1:0]      imm_ext;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [REG_IDX_W-1:0] rd;
  } id_ex_t;

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard detect: a load in EX whose destination is
// read by the instruction in decode.
module load_use_detector
  import riscv_pkg::*;
(
  input  logic [1:0]           ResultSrcE,
  input  logic [REG_IDX_W-1:0] RdE,
  input  logic [REG_IDX_W-1:0] Rs1D,
  input  logic [REG_IDX_W-1:0] Rs2D,
  output logic                 lwStall
);

  always_comb begin
    lwStall = (ResultSrcE == 2'(RES_MEM)) && (RdE != '0) &&
              ((Rs1D == RdE) || (Rs2D == RdE));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall / branch flush control and
// saturating performance counters for stall and flush events.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RegWriteD,
  input  logic                 MemWriteD,
  input  logic                 JumpD,
  input  logic                 BranchD,
  input  logic                 ALUSrcD,
  input  logic [1:0]           ResultSrcD,
  input  logic [ALUCTRL_W-1:0] ALUControlD,
  input  logic [XLEN-1:0]      RD1D,
  input  logic [XLEN-1:0]      RD2D,
  input  logic [XLEN-1:0]      PCD,
  input  logic [XLEN-1:0]      PCPlus4D,
  input  logic [XLEN-1:0]      ImmExtD,
  input  logic [REG_IDX_W-1:0] Rs1D,
  input  logic [REG_IDX_W-1:0] Rs2D,
  input  logic [REG_IDX_W-1:0] RdD,
  input  logic                 PCSrcE,
  output logic                 RegWriteE,
  output logic                 MemWriteE,
  output logic                 JumpE,
  output logic                 BranchE,
  output logic                 ALUSrcE,
  output logic [1:0]           ResultSrcE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic [XLEN-1:0]      RD1E,
  output logic [XLEN-1:0]      RD2E,
  output logic [XLEN-1:0]      PCE,
  output logic [XLEN-1:0]      PCPlus4E,
  output logic [XLEN-1:0]      ImmExtE,
  output logic [REG_IDX_W-1:0] Rs1E,
  output logic [REG_IDX_W-1:0] Rs2E,
  output logic [REG_IDX_W-1:0] RdE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic [CNT_W-1:0]     LoadStallCnt,
  output logic [CNT_W-1:0]     FlushCnt
);

  id_ex_t d_bus;
  id_ex_t e_q;
  logic   lw_stall;

  load_use_detector u_load_use_detector (
    .ResultSrcE (e_q.result_src),
    .RdE        (e_q.rd),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .lwStall    (lw_stall)
  );

  always_comb begin
    StallF = lw_stall;
    StallD = lw_stall;
    FlushD = PCSrcE;
    FlushE = lw_stall | PCSrcE;
  end

  always_comb begin
    d_bus = '{
      reg_write:   RegWriteD,
      mem_write:   MemWriteD,
      jump:        JumpD,
      branch:      BranchD,
      alu_src:     ALUSrcD,
      result_src:  ResultSrcD,
      alu_control: ALUControlD,
      rd1:         RD1D,
      rd2:         RD2D,
      pc:          PCD,
      pc_plus4:    PCPlus4D,
      imm_ext:     ImmExtD,
      rs1:         Rs1D,
      rs2:         Rs2D,
      rd:          RdD
    };
  end

  // No hold mode: a stall always becomes a bubble in EX while IF/ID holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        e_q <= '0;
    else if (FlushE) e_q <= '0;
    else             e_q <= d_bus;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      LoadStallCnt <= '0;
      FlushCnt     <= '0;
    end else begin
      if (lw_stall && (LoadStallCnt != '1)) LoadStallCnt <= LoadStallCnt + CNT_W'(1);
      if (PCSrcE && (FlushCnt != '1))       FlushCnt     <= FlushCnt + CNT_W'(1);
    end
  end

  assign RegWriteE   = e_q.reg_write;
  assign MemWriteE   = e_q.mem_write;
  assign JumpE       = e_q.jump;
  assign BranchE     = e_q.branch;
  assign ALUSrcE     = e_q.alu_src;
  assign ResultSrcE  = e_q.result_src;
  assign ALUControlE = e_q.alu_control;
  assign RD1E        = e_q.rd1;
  assign RD2E        = e_q.rd2;
  assign PCE         = e_q.pc;
  assign PCPlus4E    = e_q.pc_plus4;
  assign ImmExtE     = e_q.imm_ext;
  assign Rs1E        = e_q.rs1;
  assign Rs2E        = e_q.rs2;
  assign RdE         = e_q.rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes expected per-cycle state
// from a behavioural model; a monitor pops and compares before each edge.
module tb_id_ex_stage;

  localparam int CNT_W = 3;
  localparam int SAT   = (1 << CNT_W) - 1;
  localparam int EW    = 185;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RegWriteD = 0, MemWriteD = 0, JumpD = 0, BranchD = 0, ALUSrcD = 0;
  logic [1:0]  ResultSrcD = '0;
  logic [2:0]  ALUControlD = '0;
  logic [31:0] RD1D = '0, RD2D = '0, PCD = '0, PCPlus4D = '0, ImmExtD = '0;
  logic [4:0]  Rs1D = '0, Rs2D = '0, RdD = '0;
  logic        PCSrcE = 0;

  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        StallF, StallD, FlushD, FlushE;
  logic [CNT_W-1:0] LoadStallCnt, FlushCnt;

  id_ex_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
    .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .PCSrcE(PCSrcE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .LoadStallCnt(LoadStallCnt), .FlushCnt(FlushCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    ctl;  // {StallF, StallD, FlushD, FlushE}
    logic [EW-1:0] e;
    int            lc;
    int            fc;
    string         tag;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   stim_done = 0;

  // Behavioural model: EX contents as the decoded instruction it holds
  logic [EW-1:0] m_e;
  logic [1:0]    m_res;
  logic [4:0]    m_rd;
  int            m_lc, m_fc;

  function automatic logic [EW-1:0] d_vec();
    return {RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD,
            RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD};
  endfunction

  function automatic logic [EW-1:0] e_vec();
    return {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
            RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE};
  endfunction

  task automatic push_expect(input string tag, output bit stall);
    exp_t x;
    stall = (m_res == 2'b01) && (m_rd != 0) && (Rs1D == m_rd || Rs2D == m_rd);
    x.ctl = {stall, stall, PCSrcE, stall | PCSrcE};
    x.e   = m_e;
    x.lc  = m_lc;
    x.fc  = m_fc;
    x.tag = tag;
    q.push_back(x);
  endtask

  task automatic randomize_payload();
    MemWriteD   = 1'($urandom);
    JumpD       = 1'($urandom);
    BranchD     = 1'($urandom);
    ALUSrcD     = 1'($urandom);
    ALUControlD = 3'($urandom);
    RD1D = $urandom; RD2D = $urandom; PCD = $urandom; ImmExtD = $urandom;
    PCPlus4D = PCD + 32'd4;
  endtask

  // One clock of stimulus; model advances as the coming edge would
  task automatic step(input logic [4:0] rs1, rs2, rd, input logic [1:0] res,
                      input logic rw, input logic pcs, input string tag);
    bit stall;
    @(negedge clk); #1;
    randomize_payload();
    Rs1D = rs1; Rs2D = rs2; RdD = rd; ResultSrcD = res; RegWriteD = rw; PCSrcE = pcs;
    push_expect(tag, stall);
    if (stall || pcs) m_e = '0;
    else              m_e = d_vec();
    m_res = (stall || pcs) ? 2'b00 : res;
    m_rd  = (stall || pcs) ? 5'd0  : rd;
    if (stall && m_lc < SAT) m_lc++;
    if (pcs   && m_fc < SAT) m_fc++;
  endtask

  // Reset asserted mid-cycle with live, nonzero decode inputs
  task automatic mid_reset();
    bit stall;
    @(negedge clk); #1;
    randomize_payload();
    Rs1D = 5'd3; Rs2D = 5'd4; RdD = 5'd3; ResultSrcD = 2'b01; RegWriteD = 1; PCSrcE = 0;
    #1 rst = 1'b0;
    m_e = '0; m_res = '0; m_rd = '0; m_lc = 0; m_fc = 0;
    push_expect("reset", stall);
    @(posedge clk); #1 rst = 1'b1;
  endtask

  // Monitor: compares the oldest expectation just before each rising edge
  initial begin
    exp_t x;
    forever begin
      @(negedge clk); #4;
      if (q.size() > 0) begin
        x = q.pop_front();
        n_checks++;
        if ({StallF, StallD, FlushD, FlushE} !== x.ctl) begin
          n_fail++;
          $display("FAIL %s ctl: got %b expected %b", x.tag, {StallF, StallD, FlushD, FlushE}, x.ctl);
        end
        n_checks++;
        if (e_vec() !== x.e) begin
          n_fail++;
          $display("FAIL %s estate: got %h expected %h", x.tag, e_vec(), x.e);
        end
        n_checks++;
        if ($isunknown(LoadStallCnt) || int'(LoadStallCnt) != x.lc) begin
          n_fail++;
          $display("FAIL %s LoadStallCnt: got %0d expected %0d", x.tag, LoadStallCnt, x.lc);
        end
        n_checks++;
        if ($isunknown(FlushCnt) || int'(FlushCnt) != x.fc) begin
          n_fail++;
          $display("FAIL %s FlushCnt: got %0d expected %0d", x.tag, FlushCnt, x.fc);
        end
      end else if (stim_done) begin
        break;
      end
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] a, b, r;
    logic [1:0] rs;
    m_e = 'x; m_res = 'x; m_rd = 'x; m_lc = 0; m_fc = 0;
    mid_reset();

    // load x5, then consumer of x5 stalls one cycle, then proceeds
    step(5'd1, 5'd2, 5'd5, 2'b01, 1, 0, "load");
    step(5'd5, 5'd6, 5'd8, 2'b00, 1, 0, "lu_stall");
    step(5'd5, 5'd6, 5'd8, 2'b00, 1, 0, "lu_held");
    // x0 destination load: no stall
    step(5'd1, 5'd2, 5'd0, 2'b01, 1, 0, "load_x0");
    step(5'd3, 5'd0, 5'd7, 2'b00, 1, 0, "x0_nostall");
    // ALU producer x7 consumed next: forwarding case, no stall
    step(5'd7, 5'd1, 5'd9, 2'b00, 1, 0, "alu_fwd");
    // branch flush of a valid decode instruction
    step(5'd1, 5'd2, 5'd9, 2'b00, 1, 1, "br_flush");
    step(5'd1, 5'd2, 5'd10, 2'b00, 1, 0, "post_flush");
    // simultaneous load-use and taken branch
    step(5'd1, 5'd2, 5'd11, 2'b01, 1, 0, "load2");
    step(5'd11, 5'd2, 5'd12, 2'b00, 1, 1, "both");
    step(5'd11, 5'd2, 5'd12, 2'b00, 1, 0, "after_both");

    // saturation: load-use every other cycle for 20 cycles
    mid_reset();
    for (int i = 0; i < 20; i++) step(5'd5, 5'd1, 5'd5, 2'b01, 1, 0, "sat_lc");
    for (int i = 0; i < 10; i++) step(5'd1, 5'd2, 5'd3, 2'b00, 1, 1, "sat_fc");

    // random traffic, biased toward hazards
    for (int i = 0; i < 400; i++) begin
      a  = ($urandom_range(0, 2) == 0) ? m_rd : 5'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? m_rd : 5'($urandom);
      r  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 6));
      rs = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'($urandom);
      step(a, b, r, rs, 1'($urandom), ($urandom_range(0, 4) == 0), "rand");
      if (i == 200) mid_reset();
    end

    // reset right after a pending stall discards it
    step(5'd1, 5'd2, 5'd6, 2'b01, 1, 0, "load_pre_rst");
    mid_reset();
    step(5'd6, 5'd6, 5'd2, 2'b00, 1, 0, "no_stall_post_rst");

    @(negedge clk);
    stim_done = 1;
  end

endmodule
